// File: rtl/soc_video_pkg.sv
// Shared video-subsystem definitions: PLL supervisor state encoding and default timing constants.
package soc_video_pkg;

    typedef enum logic [2:0] {
        ST_RESET_PLL = 3'd0,
        ST_WAIT_LOCK = 3'd1,
        ST_STABILIZE = 3'd2,
        ST_RUN       = 3'd3,
        ST_FAIL      = 3'd4
    } pll_state_e;

    // Defaults sized for a 50 MHz reference clock.
    localparam int DEF_PLL_RST_CYCLES = 64;
    localparam int DEF_LOCK_TIMEOUT   = 500000;
    localparam int DEF_STABLE_CYCLES  = 65536;
    localparam int DEF_MAX_RETRIES    = 4;
    localparam int DEF_CNT_W          = 20;

endpackage

// File: rtl/sync_bit.sv
// Multi-stage flop synchronizer for a single asynchronous level signal.
module sync_bit #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] sync_q;
    logic [STAGES-1:0] sync_d;

    always_comb begin
        sync_d = (sync_q << 1) | STAGES'(d);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
        end else begin
            sync_q <= sync_d;
        end
    end

    assign q = sync_q[STAGES-1];

endmodule

// File: rtl/video_pll_lock_supervisor.sv
// Sequences the video PLL reset, qualifies a stable lock and gates the video pipeline reset,
// retrying on lock timeout and recovering after loss of lock.
module video_pll_lock_supervisor
    import soc_video_pkg::*;
#(
    parameter int PLL_RST_CYCLES = DEF_PLL_RST_CYCLES,
    parameter int LOCK_TIMEOUT   = DEF_LOCK_TIMEOUT,
    parameter int STABLE_CYCLES  = DEF_STABLE_CYCLES,
    parameter int MAX_RETRIES    = DEF_MAX_RETRIES,
    parameter int CNT_W          = DEF_CNT_W
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       pll_locked,
    input  logic       retry_req,
    input  logic       clear_lost,
    output logic       pll_rst,
    output logic       video_reset_n,
    output logic       lock_ok,
    output logic       lock_fail,
    output logic       lost_lock,
    output logic [3:0] retry_count
);

    localparam logic [CNT_W-1:0] RST_LAST     = CNT_W'(PLL_RST_CYCLES - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] STABLE_LAST  = CNT_W'(STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_SAT      = {CNT_W{1'b1}};
    localparam logic [3:0]       RETRY_MAX    = 4'(MAX_RETRIES);

    logic             locked_s;
    pll_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [3:0]       retry_q, retry_d;
    logic             lost_q, lost_d;
    logic             pll_rst_q, pll_rst_d;
    logic             vrst_n_q, vrst_n_d;
    logic             lock_ok_q, lock_ok_d;
    logic             lock_fail_q, lock_fail_d;

    sync_bit #(
        .STAGES (2)
    ) u_lock_sync (
        .clk   (clk),
        .rst_n (reset_n),
        .d     (pll_locked),
        .q     (locked_s)
    );

    always_comb begin
        state_d = state_q;
        retry_d = retry_q;
        lost_d  = lost_q;

        case (state_q)
            ST_RESET_PLL: begin
                if (cnt_q == RST_LAST) begin
                    state_d = ST_WAIT_LOCK;
                end
            end
            ST_WAIT_LOCK: begin
                // A lock arriving on the timeout cycle wins over charging a retry.
                if (locked_s) begin
                    state_d = ST_STABILIZE;
                end else if (cnt_q == TIMEOUT_LAST) begin
                    retry_d = retry_q + 4'd1;
                    state_d = ((retry_q + 4'd1) == RETRY_MAX) ? ST_FAIL : ST_RESET_PLL;
                end
            end
            ST_STABILIZE: begin
                if (!locked_s) begin
                    state_d = ST_WAIT_LOCK;
                end else if (cnt_q == STABLE_LAST) begin
                    state_d = ST_RUN;
                    retry_d = 4'd0;
                end
            end
            ST_RUN: begin
                if (!locked_s) begin
                    state_d = ST_RESET_PLL;
                end
            end
            ST_FAIL: begin
                if (retry_req) begin
                    state_d = ST_RESET_PLL;
                    retry_d = 4'd0;
                end
            end
            default: begin
                state_d = ST_RESET_PLL;
            end
        endcase

        if (state_d != state_q) begin
            cnt_d = '0;
        end else if (cnt_q == CNT_SAT) begin
            cnt_d = cnt_q;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end

        // Set has priority over a coincident clear so a fresh drop is never lost.
        if (clear_lost) begin
            lost_d = 1'b0;
        end
        if (state_q == ST_RUN && !locked_s) begin
            lost_d = 1'b1;
        end

        pll_rst_d   = (state_d == ST_RESET_PLL);
        vrst_n_d    = (state_d == ST_RUN);
        lock_ok_d   = (state_d == ST_RUN);
        lock_fail_d = (state_d == ST_FAIL);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ST_RESET_PLL;
            cnt_q       <= '0;
            retry_q     <= 4'd0;
            lost_q      <= 1'b0;
            pll_rst_q   <= 1'b1;
            vrst_n_q    <= 1'b0;
            lock_ok_q   <= 1'b0;
            lock_fail_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            retry_q     <= retry_d;
            lost_q      <= lost_d;
            pll_rst_q   <= pll_rst_d;
            vrst_n_q    <= vrst_n_d;
            lock_ok_q   <= lock_ok_d;
            lock_fail_q <= lock_fail_d;
        end
    end

    assign pll_rst       = pll_rst_q;
    assign video_reset_n = vrst_n_q;
    assign lock_ok       = lock_ok_q;
    assign lock_fail     = lock_fail_q;
    assign lost_lock     = lost_q;
    assign retry_count   = retry_q;

endmodule
